// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: default widths, port id, read tag.
// The read tag follows an accepted read down the latency pipe to steer its response.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Read-tag delay line: RD_LAT cycles from push to pop, synchronous clear, no backpressure.
// Its output lines up with mem_data_out for the read that pushed the tag.
module mem_rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two masters; grant is same-cycle.
// Reads respond RD_LAT cycles after accept; responses cannot be stalled, requests wait via ready.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  port_id_t last_gnt;
  logic     gnt0;
  logic     gnt1;
  logic     gnt_any;
  logic     gnt_we;
  rd_tag_t  tag_in;
  rd_tag_t  tag_out;

  // On contention the master that did not win last time takes the slot.
  assign gnt0    = !reset && req0_valid && (!req1_valid || last_gnt == 1'b1);
  assign gnt1    = !reset && req1_valid && (!req0_valid || last_gnt == 1'b0);
  assign gnt_any = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (gnt_any) begin
      last_gnt <= gnt1;
    end
  end

  always_comb begin
    gnt_we      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (gnt1) begin
      gnt_we      = req1_we;
      mem_addr    = req1_addr;
      mem_data_in = req1_wdata;
    end else if (gnt0) begin
      gnt_we      = req0_we;
      mem_addr    = req0_addr;
      mem_data_in = req0_wdata;
    end
  end

  assign mem_wr_en = gnt_any && gnt_we;
  assign mem_rd_en = gnt_any && !gnt_we;

  assign tag_in.valid = mem_rd_en;
  assign tag_in.port  = gnt1;

  mem_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gated by reset so a read landing in a reset cycle is dropped, not delivered.
  assign rsp0_valid = !reset && tag_out.valid && (tag_out.port == 1'b0);
  assign rsp1_valid = !reset && tag_out.valid && (tag_out.port == 1'b1);
  assign rsp0_rdata = rsp0_valid ? mem_data_out : '0;
  assign rsp1_rdata = rsp1_valid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: behavioural 16x8 memory plus an abstract reference model
// (array memory, expected-response slots, last-winner bit) checked every cycle.
module tb_mem_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid;
  logic [7:0] rsp1_rdata;
  logic       mem_wr_en, mem_rd_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Single-port memory with one-cycle registered read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_addr];
  end

  // Reference model state.
  logic [7:0] ref_mem [16];
  bit         last_was_m1 = 1'b1;
  bit         pend_v [2];
  logic [7:0] pend_d [2];
  int         grant_log [$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r,
                     input bit v0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                     input bit v1, input bit w1, input logic [3:0] a1, input logic [7:0] d1);
    bit         g0, g1, rv0, rv1;
    logic [3:0] ea;
    logic [7:0] ed;
    reset = r;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
    // Alone wins; on a tie the master that did not win last time wins.
    g0 = !r && v0 && (!v1 || last_was_m1);
    g1 = !r && v1 && !g0;
    ea = g0 ? a0 : (g1 ? a1 : 4'h0);
    ed = g0 ? d0 : (g1 ? d1 : 8'h00);
    chk("req0_ready", {15'd0, req0_ready}, {15'd0, g0});
    chk("req1_ready", {15'd0, req1_ready}, {15'd0, g1});
    chk("mem_wr_en", {15'd0, mem_wr_en}, {15'd0, (g0 && w0) || (g1 && w1)});
    chk("mem_rd_en", {15'd0, mem_rd_en}, {15'd0, (g0 && !w0) || (g1 && !w1)});
    chk("mem_addr", {12'd0, mem_addr}, {12'd0, ea});
    chk("mem_data_in", {8'd0, mem_data_in}, {8'd0, ed});
    rv0 = !r && pend_v[0];
    rv1 = !r && pend_v[1];
    chk("rsp0_valid", {15'd0, rsp0_valid}, {15'd0, rv0});
    chk("rsp1_valid", {15'd0, rsp1_valid}, {15'd0, rv1});
    chk("rsp0_rdata", {8'd0, rsp0_rdata}, {8'd0, rv0 ? pend_d[0] : 8'h00});
    chk("rsp1_rdata", {8'd0, rsp1_rdata}, {8'd0, rv1 ? pend_d[1] : 8'h00});
    @(posedge clk);
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    if (r) begin
      last_was_m1 = 1'b1;
    end else if (g0 || g1) begin
      grant_log.push_back(g1 ? 1 : 0);
      if (g0 ? w0 : w1) begin
        ref_mem[ea] = ed;
      end else begin
        pend_v[g1] = 1'b1;
        pend_d[g1] = ref_mem[ea];
      end
      last_was_m1 = g1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] wr_vals [3];
    wr_vals[0] = 8'h24; wr_vals[1] = 8'h81; wr_vals[2] = 8'h09;
    reset = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;

    // Reset with both masters requesting: no ready, no memory strobe.
    cyc(1, 1, 1, 4'h1, 8'h11, 1, 0, 4'h2, 8'h22);
    cyc(1, 1, 1, 4'h1, 8'h11, 1, 0, 4'h2, 8'h22);

    // Master 0 alone: three writes then three reads, back to back.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4'(i), wr_vals[i], 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'(i), 8'h00, 0, 0, 0, 0);
    idle(1);
    chk("m0_read_back_addr2", {8'd0, ref_mem[2]}, 16'h0009);

    // Both continuously valid: grants alternate starting with m0.
    grant_log.delete();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 4'h3, 8'h63, 1, 1, 4'h4, 8'h0D);
    chk("alt_grant_count", 16'(grant_log.size()), 16'd6);
    for (int i = 0; i < grant_log.size(); i++) chk("alt_grant_order", 16'(grant_log[i]), 16'(i % 2));

    // Cross-master write then read of the same address.
    cyc(0, 0, 0, 0, 0, 1, 1, 4'h5, 8'h8D);
    cyc(0, 1, 0, 4'h5, 8'h00, 0, 0, 0, 0);
    idle(1);

    // Interleaved reads from both masters.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc(0, 1, 0, 4'h0, 8'h00, 0, 0, 0, 0);
      else            cyc(0, 0, 0, 0, 8'h00, 1, 0, 4'h1, 8'h00);
    end
    idle(1);

    // m0 accepted last so m1 holds tie priority; reset right after a read accept.
    cyc(0, 1, 0, 4'h2, 8'h00, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    grant_log.delete();
    cyc(0, 1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00);
    chk("post_reset_first_grant", 16'(grant_log[0]), 16'd0);
    idle(1);

    // Five idle cycles, then re-read everything written so far.
    idle(5);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 4'(i), 8'h00, 0, 0, 0, 0);
    idle(1);

    // Fill the whole memory so random reads always have a defined model value.
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1, 1, 4'(i), 8'($urandom));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom),
          $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port 16x8 memory block (wr_en/rd_en/addr/data_in/data_out interface) between two independent masters.
- Each master uses a valid/ready request channel plus a read-response channel.
- The arbiter issues at most one memory access per cycle and routes read data back to the master that issued the read.
- Sits directly in front of the memory instance; masters never drive the memory.

Parameters:
- ADDR_W, 4, memory address width (16 locations).
- DATA_W, 8, memory data width.
- RD_LAT, 1, cycles from the accepting clock edge to mem_data_out valid (1..4).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  master 0 request present.
- req0_ready  out  1  master 0 request accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  master 0 address.
- req0_wdata  in  DATA_W  master 0 write data.
- rsp0_valid  out  1  master 0 read data valid.
- rsp0_rdata  out  DATA_W  master 0 read data.
- req1_* / rsp1_*  same set, same widths, for master 1.
- mem_wr_en  out  1  to memory wr_en.
- mem_rd_en  out  1  to memory rd_en.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: rsp0_valid = rsp1_valid = 0; last_gnt = 1, so master 0 wins the first contention. The read-tag pipeline is cleared, so in-flight reads are dropped and produce no response. reqN_ready, mem_wr_en and mem_rd_en are forced to 0 during reset.
- Accept: a request is accepted on the rising edge where reqN_valid && reqN_ready.
- Ready generation: reqN_ready is combinational. At most one ready is high per cycle. Ready does not depend on the other master's ready.
- Arbitration:
  - Only one master valid: that master is granted.
  - Both masters valid: the master not in last_gnt is granted.
  - last_gnt updates to the granted port on every accept and holds when there is no grant.
- Fairness: a continuously valid master waits at most 1 cycle.
- Memory drive in the grant cycle (combinational pass-through):
  - mem_wr_en = granted we.
  - mem_rd_en = !granted we.
  - mem_addr and mem_data_in come from the granted master.
  - With no grant, mem_wr_en = mem_rd_en = 0; mem_addr and mem_data_in are 0.
- mem_wr_en and mem_rd_en are never both high.
- Read tagging: each accepted read pushes {1, port} into an RD_LAT-deep shift register; writes and idle cycles push {0, x}.
- Read response: when the output stage is valid, rsp<port>_valid is high for exactly one cycle, and rsp<port>_rdata = mem_data_out. The other master's rsp_valid stays 0.
- rspN_rdata is 0 whenever rspN_valid is 0.
- No backpressure on responses: masters must sink them.
- Back-to-back accesses: accesses are fully pipelined, one per cycle, with no bubbles.
- Same-address write then read (any master mix): the read returns the new data, because the write commits at the edge before the read is sampled. The arbiter does no forwarding.
- Simultaneous events: a response for an old read and the grant of a new request in the same cycle are independent and both occur.
- Reset mid-operation: pending responses are discarded; arbitration restarts with master 0 priority.
- Address space: no address checking; addresses wrap within 2^ADDR_W by width.

Decomposition:
- Package mem_arb_pkg: ADDR_W/DATA_W defaults, port-id type (1 bit), and the rd_tag_t struct {valid, port}.
- Sub-module mem_rd_tag_pipe: RD_LAT-deep tag shift register with synchronous clear on reset.
- Arbitration logic and muxing stay in the top module.

Test Plan:
- Reset, then master 0 alone writes 0x24, 0x81, 0x09 to addresses 0..2 on consecutive cycles, then reads addresses 0..2 -> req0_ready is high every cycle; rsp0_valid occurs 1 cycle after each read accept with 0x24, 0x81, 0x09; rsp1_valid stays 0.
- Both masters continuously valid (m0 writes addr 3 = 0x63, m1 writes addr 4 = 0x0D, repeated) -> grants alternate m0, m1, m0, ... starting with m0 after reset; no cycle has both readies high.
- m1 writes addr 5 = 0x8D; in the next cycle m0 reads addr 5 -> rsp0_rdata = 0x8D one cycle after accept, and only rsp0_valid pulses.
- Interleaved reads: m0 reads addr 0 and m1 reads addr 1 in alternating cycles -> each response is routed to the issuing master with the correct data; rsp0_valid and rsp1_valid are never high together.
- Assert reset in the cycle after a read accept -> no rsp_valid is produced; the first grant after reset goes to m0 even if m1 held priority.
- No valid requests for 5 cycles -> mem_wr_en = mem_rd_en = 0 and no responses; memory contents are unchanged when re-read.
